// File: rtl/apb_rw_regs.sv
// APB4 slave register file with byte strobes, read-only mask and hardware load port.
// Optional access-phase wait states enabled by defining APB_RW_REGS_WAIT_EN.
package apb_rw_regs_pkg;
  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;
endpackage

module apb_rw_regs #(
  parameter int unsigned NoApbRegs    = 32'd1,
  parameter int unsigned ApbAddrWidth = 32'd32,
  parameter int unsigned RegDataWidth = 32'd32,
  parameter logic [NoApbRegs-1:0] ReadOnly = '0,
  parameter logic [NoApbRegs-1:0][RegDataWidth-1:0] RegRstVal = '0,
  parameter int unsigned WaitCycles   = 32'd0,
  parameter type req_t  = apb_rw_regs_pkg::apb_req_t,
  parameter type resp_t = apb_rw_regs_pkg::apb_resp_t
) (
  input  logic                                     pclk_i,
  input  logic                                     preset_ni,
  input  req_t                                     req_i,
  output resp_t                                    resp_o,
  input  logic [ApbAddrWidth-1:0]                  base_addr_i,
  input  logic [NoApbRegs-1:0][RegDataWidth-1:0]   reg_d_i,
  input  logic [NoApbRegs-1:0]                     reg_load_i,
  output logic [NoApbRegs-1:0][RegDataWidth-1:0]   reg_q_o,
  output logic [NoApbRegs-1:0]                     reg_wr_o
);

  localparam int unsigned DataW = $bits(req_i.pwdata);
  localparam logic [31:0] ErrData = 32'h0BAD_B10C;

  logic [ApbAddrWidth-1:0]                 offset;
  logic [ApbAddrWidth-1:0]                 word_idx;
  logic [NoApbRegs-1:0]                    hit_vec;
  logic                                    hit;
  logic                                    ro_hit;
  logic [DataW-1:0]                        rdata;
  logic                                    access;
  logic                                    ready;
  logic                                    err;
  logic                                    wr_ok;
  logic [NoApbRegs-1:0][RegDataWidth-1:0]  reg_next;
  logic [NoApbRegs-1:0]                    wr_next;

  assign offset   = req_i.paddr - base_addr_i;
  assign word_idx = offset >> 2;
  assign access   = req_i.psel & req_i.penable;

  // Decode by comparing against every register index, so no out-of-range selects occur.
  always_comb begin
    hit_vec = '0;
    ro_hit  = 1'b0;
    rdata   = '0;
    for (int i = 0; i < NoApbRegs; i++) begin
      if ((req_i.paddr >= base_addr_i) && (word_idx == ApbAddrWidth'(i))) begin
        hit_vec[i] = 1'b1;
        ro_hit     = ReadOnly[i];
        rdata      = DataW'(reg_q_o[i]);
      end
    end
  end

  assign hit   = |hit_vec;
  assign err   = ~hit | (req_i.pwrite & ro_hit);
  assign wr_ok = access & ready & req_i.pwrite & ~err;

`ifdef APB_RW_REGS_WAIT_EN
  localparam int unsigned CntW = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;
  logic [CntW-1:0] wait_cnt;

  assign ready = access & (wait_cnt == CntW'(WaitCycles));

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      wait_cnt <= '0;
    end else if (!req_i.psel || ready) begin
      wait_cnt <= '0;
    end else if (access) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign ready = access;
`endif

  always_comb begin
    resp_o         = '0;
    resp_o.pready  = ready;
    resp_o.pslverr = req_i.psel & err;
    if (req_i.psel) begin
      resp_o.prdata = err ? DataW'(ErrData) : rdata;
    end
  end

  // Hardware load is applied last so it overrides an APB write and suppresses its pulse.
  always_comb begin
    reg_next = reg_q_o;
    wr_next  = '0;
    for (int i = 0; i < NoApbRegs; i++) begin
      if (wr_ok && hit_vec[i]) begin
        for (int k = 0; k < RegDataWidth; k++) begin
          if (req_i.pstrb[k/8]) reg_next[i][k] = req_i.pwdata[k];
        end
        wr_next[i] = 1'b1;
      end
      if (reg_load_i[i]) begin
        reg_next[i] = reg_d_i[i];
        wr_next[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      reg_q_o  <= RegRstVal;
      reg_wr_o <= '0;
    end else begin
      reg_q_o  <= reg_next;
      reg_wr_o <= wr_next;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{req_i.pprot, offset[1:0]};

endmodule

// File: tb/tb_apb_rw_regs.sv
// Directed bench for apb_rw_regs: 4 registers at 0x100, register 2 read-only.
// Wait-state steps run only when APB_RW_REGS_WAIT_EN is defined (WaitCycles=2).
module tb_apb_rw_regs;
  import apb_rw_regs_pkg::*;

  localparam logic [3:0][31:0] RstVals = {32'h0, 32'h0, 32'hCAFE_0001, 32'h0};

  logic             clk;
  logic             rst_n;
  apb_req_t         req;
  apb_resp_t        resp;
  logic [31:0]      base;
  logic [3:0][31:0] reg_d;
  logic [3:0]       reg_load;
  logic [3:0][31:0] reg_q;
  logic [3:0]       reg_wr;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        er;
  int          nw;

  apb_rw_regs #(
    .NoApbRegs   (4),
    .ApbAddrWidth(32),
    .RegDataWidth(32),
    .ReadOnly    (4'b0100),
    .RegRstVal   (RstVals),
    .WaitCycles  (2)
  ) dut (
    .pclk_i     (clk),
    .preset_ni  (rst_n),
    .req_i      (req),
    .resp_o     (resp),
    .base_addr_i(base),
    .reg_d_i    (reg_d),
    .reg_load_i (reg_load),
    .reg_q_o    (reg_q),
    .reg_wr_o   (reg_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One APB transfer; returns data/error of the completing cycle and the number of wait cycles.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic slverr, output int waits);
    @(negedge clk);
    req.paddr   = addr;
    req.pwrite  = wr;
    req.pwdata  = data;
    req.pstrb   = strb;
    req.psel    = 1'b1;
    req.penable = 1'b0;
    @(negedge clk);
    req.penable = 1'b1;
    waits = 0;
    #1;
    while (!resp.pready && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!resp.pready) chk("pready_timeout", 32'(resp.pready), 32'd1);
    rdata  = resp.prdata;
    slverr = resp.pslverr;
    @(posedge clk);
    #1;
    req.psel    = 1'b0;
    req.penable = 1'b0;
  endtask

  initial begin
    req      = '0;
    base     = 32'h100;
    reg_d    = '0;
    reg_load = '0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q0", reg_q[0], 32'h0);
    chk("rst_q1", reg_q[1], 32'hCAFE_0001);
    chk("rst_wr", 32'(reg_wr), 32'h0);
    chk("idle_prdata", resp.prdata, 32'h0);
    chk("idle_slverr", 32'(resp.pslverr), 32'h0);
    rst_n = 1'b1;

    apb_xfer(32'h104, 1'b0, 32'h0, 4'h0, rd, er, nw);
    chk("rd104_data", rd, 32'hCAFE_0001);
    chk("rd104_err", 32'(er), 32'h0);
`ifndef APB_RW_REGS_WAIT_EN
    chk("rd104_waits", 32'(nw), 32'd0);
`endif

    apb_xfer(32'h108, 1'b1, 32'h1234_5678, 4'hF, rd, er, nw);
    chk("ro_err", 32'(er), 32'h1);
    chk("ro_prdata", rd, 32'h0BAD_B10C);
    chk("ro_q2", reg_q[2], 32'h0);
    chk("ro_wr", 32'(reg_wr), 32'h0);

    apb_xfer(32'h100, 1'b1, 32'hAABB_CCDD, 4'b0101, rd, er, nw);
    chk("strb_err", 32'(er), 32'h0);
    chk("strb_wr_pulse", 32'(reg_wr), 32'h1);
    @(posedge clk);
    #1;
    chk("strb_wr_clear", 32'(reg_wr), 32'h0);
    apb_xfer(32'h100, 1'b0, 32'h0, 4'h0, rd, er, nw);
    chk("strb_rd", rd, 32'h00BB_00DD);

    apb_xfer(32'h110, 1'b0, 32'h0, 4'h0, rd, er, nw);
    chk("rd110_err", 32'(er), 32'h1);
    chk("rd110_data", rd, 32'h0BAD_B10C);
    apb_xfer(32'h0FC, 1'b0, 32'h0, 4'h0, rd, er, nw);
    chk("rd0fc_err", 32'(er), 32'h1);
    chk("rd0fc_data", rd, 32'h0BAD_B10C);

    reg_d[3]    = 32'h55;
    reg_load[3] = 1'b1;
    apb_xfer(32'h10C, 1'b1, 32'h1, 4'hF, rd, er, nw);
    reg_load = '0;
    chk("ld_err", 32'(er), 32'h0);
    chk("ld_q3", reg_q[3], 32'h55);
    chk("ld_wr", 32'(reg_wr), 32'h0);

    apb_xfer(32'h10C, 1'b1, 32'hFFFF_FFFF, 4'h0, rd, er, nw);
    chk("nostrb_wr", 32'(reg_wr), 32'h8);
    chk("nostrb_q3", reg_q[3], 32'h55);

    apb_xfer(32'h10C, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, nw);
    apb_xfer(32'h10C, 1'b0, 32'h0, 4'h0, rd, er, nw);
    chk("full_rd", rd, 32'hDEAD_BEEF);

    @(negedge clk);
    reg_d[2]    = 32'h77;
    reg_load[2] = 1'b1;
    @(negedge clk);
    reg_load = '0;
    chk("hwld_ro_q2", reg_q[2], 32'h77);
    chk("hwld_ro_wr", 32'(reg_wr), 32'h0);

`ifdef APB_RW_REGS_WAIT_EN
    apb_xfer(32'h104, 1'b0, 32'h0, 4'h0, rd, er, nw);
    chk("wait_cnt", 32'(nw), 32'd2);
    chk("wait_data", rd, 32'hCAFE_0001);
    @(negedge clk);
    req.paddr = 32'h104; req.pwrite = 1'b0; req.psel = 1'b1; req.penable = 1'b0;
    @(negedge clk);
    req.penable = 1'b1;
    #1;
    chk("abort_notready", 32'(resp.pready), 32'h0);
    @(negedge clk);
    req.psel = 1'b0; req.penable = 1'b0;
    apb_xfer(32'h104, 1'b0, 32'h0, 4'h0, rd, er, nw);
    chk("restart_waits", 32'(nw), 32'd2);
    apb_xfer(32'h110, 1'b0, 32'h0, 4'h0, rd, er, nw);
    chk("err_waits", 32'(nw), 32'd2);
`endif

    // Reset mid-transfer returns registers to their reset values immediately.
    @(negedge clk);
    req.paddr = 32'h104; req.pwrite = 1'b1; req.pwdata = 32'h1111_2222; req.pstrb = 4'hF;
    req.psel = 1'b1; req.penable = 1'b0;
    @(negedge clk);
    req.penable = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_q1", reg_q[1], 32'hCAFE_0001);
    chk("midrst_q3", reg_q[3], 32'h0);
    @(posedge clk);
    #1;
    req = '0;
    chk("midrst_hold_q1", reg_q[1], 32'hCAFE_0001);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
